// File: rtl/alu_op_sequencer.sv
// Command-side driver for the 4-bit ALU: queues commands, drives the ALU, waits a settle
// time, captures and normalises {y,x}, and returns results in order. Optional macro: ALU_SEQ_CHECK_EN.
module alu_op_sequencer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_opcode,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic [3:0] alu_opcode,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_x,
  input  logic [3:0] alu_y,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_opcode,
  output logic [3:0] rsp_x,
  output logic [3:0] rsp_y,
  output logic       busy,
  output logic       rsp_mismatch
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the source holds
  // its payload stable while valid && !ready, and valid never drops without a transfer.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  state_t state;
  state_t state_next;

  cmd_t          mem [FIFO_DEPTH];
  cmd_t          head;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          load_rsp;
  logic          rsp_done;
  logic [CW-1:0] cnt;
  logic [7:0]    captured;

  // Keep only the bits the ALU actually writes for this opcode; result packed as {y,x}.
  function automatic logic [7:0] normalise(input logic [3:0] op, input logic [3:0] x,
                                           input logic [3:0] y);
    logic [7:0] r;
    case (op)
      4'b0000, 4'b0001, 4'b0010,
      4'b0110, 4'b0111, 4'b1000, 4'b1001: r = {4'h0, 3'b000, x[0]};
      4'b1010:                            r = {3'b000, y[0], x};
      4'b1100, 4'b1101, 4'b1110:          r = {y, x};
      default:                            r = {4'h0, x};
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------- command FIFO
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign head       = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: emptiness is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{opcode: cmd_opcode, a: cmd_a, b: cmd_b};
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = SETTLE;
      SETTLE:  if (cnt == '0) state_next = CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    load_rsp = 1'b0;
    rsp_done = 1'b0;
    case (state)
      IDLE:    pop      = !fifo_empty;
      CAPTURE: load_rsp = 1'b1;
      RESP:    rsp_done = rsp_valid && rsp_ready;
      default: ;
    endcase
  end

  assign busy = !fifo_empty || (state != IDLE);

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (pop) begin
      cnt <= SETTLE_LOAD;
    end else if (state == SETTLE && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  // ALU drives hold between pops so the ALU output stays stable through capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else if (pop) begin
      alu_opcode <= head.opcode;
      alu_a      <= head.a;
      alu_b      <= head.b;
    end
  end

  assign captured = normalise(alu_opcode, alu_x, alu_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_opcode <= '0;
      rsp_x      <= '0;
      rsp_y      <= '0;
    end else if (load_rsp) begin
      rsp_valid  <= 1'b1;
      rsp_opcode <= alu_opcode;
      rsp_x      <= captured[3:0];
      rsp_y      <= captured[7:4];
    end else if (rsp_done) begin
      rsp_valid  <= 1'b0;
    end
  end

`ifdef ALU_SEQ_CHECK_EN
  // Independent expectation of the normalised {y,x} for the operands currently driven.
  function automatic logic [7:0] model_result(input logic [3:0] op, input logic [3:0] a,
                                              input logic [3:0] b);
    logic [7:0] r;
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      4'b0000: r = {7'b0, |a};
      4'b0001: r = {7'b0, &a};
      4'b0010: r = {7'b0, ^a};
      4'b0011: r = {4'h0, a & b};
      4'b0100: r = {4'h0, a | b};
      4'b0101: r = {4'h0, a ^ b};
      4'b0110: r = {7'b0, a > b};
      4'b0111: r = {7'b0, a < b};
      4'b1000: r = {7'b0, a == b};
      4'b1001: r = {7'b0, a != b};
      4'b1010: r = {3'b000, sum};
      4'b1011: r = {4'h0, a - b};
      4'b1100: r = {4'h0, a} * {4'h0, b};
      4'b1101: r = {a, 4'h0} >> b;
      4'b1110: r = {4'h0, a} << b;
      default: r = {4'h0, ~a};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_mismatch <= 1'b0;
    end else if (load_rsp) begin
      rsp_mismatch <= (captured != model_result(alu_opcode, alu_a, alu_b));
    end
  end
`else
  assign rsp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU that leaves unwritten
// result bits holding their previous values.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_opcode;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [3:0] alu_opcode;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_x;
  logic [3:0] alu_y;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_opcode;
  logic [3:0] rsp_x;
  logic [3:0] rsp_y;
  logic       busy;
  logic       rsp_mismatch;

  int         checks   = 0;
  int         failures = 0;
  logic [11:0] exp_q[$];
  logic       exp_mm   = 1'b0;
  logic       corrupt  = 1'b0;
  logic [3:0] hold_x   = 4'hE;
  logic [3:0] hold_y   = 4'hB;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_x(alu_x), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_opcode(rsp_opcode), .rsp_x(rsp_x), .rsp_y(rsp_y),
    .busy(busy), .rsp_mismatch(rsp_mismatch)
  );

  // ---------------------------------------------------------------- clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- ALU model
  always_comb begin
    alu_x = hold_x;
    alu_y = hold_y;
    case (alu_opcode)
      4'b0000: alu_x[0] = |alu_a;
      4'b0001: alu_x[0] = &alu_a;
      4'b0010: alu_x[0] = ^alu_a;
      4'b0011: alu_x = alu_a & alu_b;
      4'b0100: alu_x = alu_a | alu_b;
      4'b0101: alu_x = alu_a ^ alu_b;
      4'b0110: alu_x[0] = alu_a > alu_b;
      4'b0111: alu_x[0] = alu_a < alu_b;
      4'b1000: alu_x[0] = alu_a == alu_b;
      4'b1001: alu_x[0] = alu_a != alu_b;
      4'b1010: {alu_y[0], alu_x} = {1'b0, alu_a} + {1'b0, alu_b};
      4'b1011: alu_x = alu_a - alu_b;
      4'b1100: {alu_y, alu_x} = {4'h0, alu_a} * {4'h0, alu_b};
      4'b1101: {alu_y, alu_x} = {alu_a, 4'h0} >> alu_b;
      4'b1110: {alu_y, alu_x} = {4'h0, alu_a} << alu_b;
      default: alu_x = ~alu_a;
    endcase
    if (corrupt) alu_x = alu_x ^ 4'h4;
  end

  always @(posedge clk) begin
    hold_x <= alu_x;
    hold_y <= alu_y;
  end

  // ---------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every response handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {20'h0, rsp_opcode, rsp_y, rsp_x}, 32'hFFFF_FFFF);
      end else begin
        check("rsp", {20'h0, rsp_opcode, rsp_y, rsp_x}, {20'h0, exp_q.pop_front()});
      end
      check("rsp_mismatch", rsp_mismatch, exp_mm);
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic push(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] ex, input logic [3:0] ey, input bit track);
    int n = 0;
    if (track) exp_q.push_back({op, ey, ex});
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("push_timeout", n, 0);
    else @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rsp_ready = v;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((busy || rsp_valid || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int lat;
    int seen;
    int n;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_opcode = '0;
    cmd_a      = '0;
    cmd_b      = '0;
    rsp_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state, then idle for ten cycles
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_drive", {alu_opcode, alu_a, alu_b}, 0);
    check("reset_rsp", {rsp_opcode, rsp_y, rsp_x}, 0);
    check("reset_mismatch", rsp_mismatch, 0);
    repeat (10) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_rsp_valid", rsp_valid, 0);
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_drive", {alu_opcode, alu_a, alu_b}, 0);

    // Add with carry and its latency
    set_ready(1'b1);
    push(4'b1010, 4'h9, 4'h8, 4'h1, 4'h1, 1'b1);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("add_latency", lat, 3);
    check("add_drive", {alu_opcode, alu_a, alu_b}, 12'hA98);
    wait_drain("add_drain");

    // Multiply and shifts, back to back
    push(4'b1100, 4'hF, 4'hF, 4'h1, 4'hE, 1'b1);
    push(4'b1110, 4'hF, 4'h4, 4'h0, 4'hF, 1'b1);
    push(4'b0110, 4'h3, 4'h2, 4'h1, 4'h0, 1'b1);
    wait_drain("seq_drain");

    // Backpressure: one in flight, four queued, sixth held
    set_ready(1'b0);
    push(4'b0011, 4'hC, 4'hA, 4'h8, 4'h0, 1'b1);
    push(4'b0100, 4'hC, 4'h3, 4'hF, 4'h0, 1'b1);
    push(4'b1011, 4'h2, 4'h5, 4'hD, 4'h0, 1'b1);
    push(4'b1101, 4'h9, 4'h2, 4'h4, 4'h2, 1'b1);
    push(4'b1000, 4'h7, 4'h7, 4'h1, 4'h0, 1'b1);
    cmd_valid  = 1'b1;
    cmd_opcode = 4'b1111;
    cmd_a      = 4'h5;
    cmd_b      = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_cmd_ready", cmd_ready, 0);
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rsp_hold", {rsp_opcode, rsp_y, rsp_x}, 12'h308);
    end
    check("stall_busy", busy, 1);
    set_ready(1'b1);
    push(4'b1111, 4'h5, 4'h0, 4'hA, 4'h0, 1'b1);
    wait_drain("stall_drain");

    // Stale upper bits from the ALU must not leak into single-bit results
    push(4'b0101, 4'h5, 4'h3, 4'h6, 4'h0, 1'b1);
    push(4'b0000, 4'h0, 4'h9, 4'h0, 4'h0, 1'b1);
    push(4'b1010, 4'hF, 4'hF, 4'hE, 4'h1, 1'b1);
    push(4'b0010, 4'h7, 4'h0, 4'h1, 4'h0, 1'b1);
    wait_drain("stale_drain");

    // Reset while settling with two commands queued
    set_ready(1'b0);
    push(4'b1001, 4'h3, 4'h4, 4'h1, 4'h0, 1'b1);
    push(4'b0100, 4'h1, 4'h1, 4'h1, 4'h0, 1'b0);
    push(4'b0011, 4'h6, 4'h3, 4'h2, 4'h0, 1'b0);
    push(4'b1111, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0);
    set_ready(1'b1);
    n = 0;
    while (alu_opcode != 4'b0100 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_settle", alu_opcode, 4'b0100);
    rst = 1'b1;
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_drive", {alu_opcode, alu_a, alu_b}, 0);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("rst_no_rsp", seen, 0);
    check("rst_busy_after", busy, 0);

`ifdef ALU_SEQ_CHECK_EN
    // Corrupted ALU output is flagged against the internal model
    corrupt = 1'b1;
    exp_mm  = 1'b1;
    push(4'b0100, 4'h1, 4'h2, 4'h7, 4'h0, 1'b1);
    wait_drain("corrupt_drain");
    corrupt = 1'b0;
    exp_mm  = 1'b0;
    push(4'b0100, 4'h1, 4'h2, 4'h3, 4'h0, 1'b1);
    wait_drain("clean_drain");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
